// File: rtl/multicyc_exec_ctrl_if.sv
// multicyc_exec_ctrl_if: EX-stage request/response bundle between the pipeline and multicyc_exec_ctrl
interface multicyc_exec_ctrl_if;
  logic        flush;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [63:0] hilo_i;
  logic        stall_o;
  logic        done_o;
  logic [63:0] hilo_o;
  logic [31:0] reg_o;
  modport master (output flush, req_valid, req_op, reg1, reg2, hilo_i, input stall_o, done_o, hilo_o, reg_o);
  modport slave  (input flush, req_valid, req_op, reg1, reg2, hilo_i, output stall_o, done_o, hilo_o, reg_o);
endinterface

// File: rtl/multicyc_exec_ctrl.sv
// multicyc_exec_ctrl: multi-cycle multiply/divide sequencer for the EX stage; MULTICYC_MADD_EN adds MADD/MADDU/MSUB/MSUBU
package multicyc_exec_pkg;
  typedef enum logic [3:0] {
    OP_NOP, OP_MULT, OP_MULTU, OP_MUL, OP_DIV, OP_DIVU,
    OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, OP_MTHI, OP_MTLO
  } oper_t;
endpackage

module multicyc_exec_ctrl
  import multicyc_exec_pkg::*;
(
  input logic clk,
  input logic rst_n,
  multicyc_exec_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIXUP, DONE} state_t;
  state_t state;
  oper_t op, op_r;
  logic is_acc, is_mul, is_div, multi, accept, sgn_in, sgn_r, neg_q, neg_r;
  logic [4:0] cnt;
  logic [31:0] a, b, rem, quo;
  logic [32:0] sh;
  logic [63:0] prod, res;
`ifdef MULTICYC_MADD_EN
  logic [63:0] hilo_r;
  assign is_acc = op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
`else
  assign is_acc = 1'b0;
`endif
  assign op = oper_t'(bus.req_op);
  assign is_mul = is_acc | (op inside {OP_MULT, OP_MULTU, OP_MUL});
  assign is_div = op inside {OP_DIV, OP_DIVU};
  assign multi = bus.req_valid & (is_mul | is_div) & ~bus.flush;
  assign accept = multi & (state == IDLE);
  assign sgn_in = op inside {OP_MULT, OP_MUL, OP_MADD, OP_MSUB, OP_DIV};
  assign sh = {rem, quo[31]};
  assign bus.stall_o = multi & (state != DONE);
  assign bus.done_o = state == DONE;
  assign bus.reg_o = (state == DONE && op_r == OP_MUL) ? res[31:0] : '0;
  assign bus.hilo_o = bus.done_o ? res : !bus.req_valid ? bus.hilo_i :
                      op == OP_MTHI ? {bus.reg1, bus.hilo_i[31:0]} :
                      op == OP_MTLO ? {bus.hilo_i[63:32], bus.reg1} : bus.hilo_i;

  function automatic logic [31:0] mag(input logic [31:0] x, input logic s);
    return (s & x[31]) ? -x : x;
  endfunction

  // sequencer: latch operands on accept, then run the multiply pipe or the restoring divider
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      op_r <= OP_NOP;
      {sgn_r, neg_q, neg_r} <= '0;
      cnt <= '0;
      {a, b, rem, quo} <= '0;
      {prod, res} <= '0;
`ifdef MULTICYC_MADD_EN
      hilo_r <= '0;
`endif
    end else if (bus.flush) state <= IDLE;
    else case (state)
      IDLE: if (accept) begin
        op_r <= op;
        sgn_r <= sgn_in;
        cnt <= '0;
        rem <= '0;
        a <= bus.reg1;
        neg_q <= sgn_in & (bus.reg1[31] ^ bus.reg2[31]);
        neg_r <= sgn_in & bus.reg1[31];
`ifdef MULTICYC_MADD_EN
        hilo_r <= bus.hilo_i;
`endif
        if (is_mul) begin
          b <= bus.reg2;
          state <= MUL;
        end else if (bus.reg2 == '0) begin
          res <= bus.hilo_i;
          state <= DONE;
        end else begin
          b <= mag(bus.reg2, sgn_in);
          quo <= mag(bus.reg1, sgn_in);
          state <= DIV;
        end
      end
      MUL: if (cnt == '0) begin
        prod <= {{32{sgn_r & a[31]}}, a} * {{32{sgn_r & b[31]}}, b};
        cnt <= cnt + 5'd1;
      end else begin
`ifdef MULTICYC_MADD_EN
        res <= (op_r inside {OP_MADD, OP_MADDU}) ? hilo_r + prod :
               (op_r inside {OP_MSUB, OP_MSUBU}) ? hilo_r - prod : prod;
`else
        res <= prod;
`endif
        state <= DONE;
      end
      DIV: begin
        rem <= (sh >= {1'b0, b}) ? 32'(sh - {1'b0, b}) : sh[31:0];
        quo <= {quo[30:0], sh >= {1'b0, b}};
        cnt <= cnt + 5'd1;
        if (cnt == 5'd31) state <= FIXUP;
      end
      FIXUP: begin
        res <= {neg_r ? -rem : rem, neg_q ? -quo : quo};
        state <= DONE;
      end
      default: state <= IDLE;
    endcase
endmodule

// File: tb/tb_multicyc_exec_ctrl.sv
// tb_multicyc_exec_ctrl: randomized scoreboard bench for multicyc_exec_ctrl against an arithmetic reference model
module tb_multicyc_exec_ctrl;
  import multicyc_exec_pkg::*;
  typedef struct {logic [63:0] h; logic [31:0] r; int due;} exp_t;
  logic clk = 0, rst_n = 0;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  exp_t sb[$];
  multicyc_exec_ctrl_if bus();
  multicyc_exec_ctrl dut(.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // every completion pulse is matched against the oldest outstanding expectation
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.done_o) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: done_o high at cycle %0d with nothing outstanding", cyc);
      end else begin
        e = sb.pop_front();
        chk("hilo_o", bus.hilo_o, e.h);
        chk("reg_o", 64'(bus.reg_o), 64'(e.r));
        chk("done_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  function automatic void model(input oper_t op, input logic [31:0] a, input logic [31:0] b, input logic [63:0] h,
                                output bit m, output int lat, output logic [63:0] eh, output logic [31:0] er);
    longint x = longint'($signed(a)), y = longint'($signed(b));
    logic [63:0] ps = 64'(x * y), pu = {32'b0, a} * {32'b0, b};
    m = 1; lat = 3; eh = h; er = '0;
    case (op)
      OP_MULT: eh = ps;
      OP_MUL: begin eh = ps; er = ps[31:0]; end
      OP_MULTU: eh = pu;
`ifdef MULTICYC_MADD_EN
      OP_MADD: eh = h + ps;
      OP_MADDU: eh = h + pu;
      OP_MSUB: eh = h - ps;
      OP_MSUBU: eh = h - pu;
`endif
      OP_DIV, OP_DIVU:
        if (b == 0) lat = 1;
        else begin
          lat = 34;
          eh = (op == OP_DIV) ? {32'(x % y), 32'(x / y)} : {a % b, a / b};
        end
      OP_MTHI: begin m = 0; eh = {a, h[31:0]}; end
      OP_MTLO: begin m = 0; eh = {h[63:32], a}; end
      default: m = 0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.req_valid = 0;
      bus.req_op = 4'($urandom_range(0, 11));
      bus.reg1 = $urandom;
      bus.hilo_i = {$urandom, $urandom};
      @(negedge clk);
      chk("idle_stall", 64'(bus.stall_o), 64'(0));
      chk("idle_hilo", bus.hilo_o, bus.hilo_i);
      chk("idle_reg", 64'(bus.reg_o), 64'(0));
      step();
    end
  endtask

  task automatic quiet();
    int nd = 0;
    bus.req_valid = 0;
    for (int i = 0; i < 40; i++) begin
      bus.hilo_i = {$urandom, $urandom};
      @(negedge clk);
      nd += int'(bus.done_o);
      if (i == 0) begin
        chk("abort_hilo", bus.hilo_o, bus.hilo_i);
        chk("abort_reg", 64'(bus.reg_o), 64'(0));
      end
      step();
    end
    chk("abort_no_done", 64'(nd), 64'(0));
  endtask

  // kind 1 = flush, kind 2 = reset, applied during cycle T+abort_at
  task automatic do_op(input oper_t op, input logic [31:0] a, input logic [31:0] b, input logic [63:0] h,
                       input int abort_at = -1, input int kind = 0);
    bit m;
    int lat, t0;
    logic [63:0] eh;
    logic [31:0] er;
    model(op, a, b, h, m, lat, eh, er);
    bus.req_valid = 1; bus.req_op = op; bus.reg1 = a; bus.reg2 = b; bus.hilo_i = h;
    t0 = cyc;
    if (!m) begin
      @(negedge clk);
      chk("pass_stall", 64'(bus.stall_o), 64'(0));
      chk("pass_hilo", bus.hilo_o, eh);
      chk("pass_reg", 64'(bus.reg_o), 64'(0));
      step();
      return;
    end
    if (abort_at < 0) sb.push_back('{eh, er, t0 + lat});
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) begin
        bus.reg1 = $urandom; bus.reg2 = $urandom; bus.hilo_i = {$urandom, $urandom};
      end
      bus.flush = (k == abort_at && kind == 1);
      rst_n = !(k == abort_at && kind == 2);
      @(negedge clk);
      chk("stall_o", 64'(bus.stall_o), 64'((k == abort_at && kind == 1) ? 1'b0 : (k != lat)));
      step();
      bus.flush = 0;
      rst_n = 1;
      if (k == abort_at) begin
        quiet();
        return;
      end
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.flush = 0; bus.req_valid = 0; bus.req_op = OP_NOP;
    bus.reg1 = 0; bus.reg2 = 0; bus.hilo_i = {$urandom, $urandom};
    rst_n = 0;
    repeat (2) step();
    @(negedge clk);
    chk("rst_done", 64'(bus.done_o), 64'(0));
    chk("rst_reg", 64'(bus.reg_o), 64'(0));
    chk("rst_stall", 64'(bus.stall_o), 64'(0));
    chk("rst_hilo", bus.hilo_o, bus.hilo_i);
    step();
    rst_n = 1;
    idle(2);
    do_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, 64'h0);
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, {$urandom, $urandom});
    do_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, {$urandom, $urandom});
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {$urandom, $urandom});
    do_op(OP_DIV, 32'h1234, 32'h0, 64'h1234_5678_9ABC_DEF0);
    do_op(OP_MUL, 32'd7, 32'd6, {$urandom, $urandom});
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {$urandom, $urandom});
    do_op(OP_MTHI, $urandom, 32'd0, {$urandom, $urandom});
    do_op(OP_MTLO, $urandom, 32'd0, {$urandom, $urandom});
    do_op(OP_MADD, 32'd2, 32'd3, 64'd5);
    do_op(OP_MSUB, 32'hFFFF_FFFF, 32'd4, 64'd1);
    do_op(OP_DIV, 32'd100, 32'd7, {$urandom, $urandom}, 10, 1);
    do_op(OP_MULT, 32'd5, 32'd9, {$urandom, $urandom}, 2, 2);
    do_op(OP_DIVU, 32'd9, 32'd3, {$urandom, $urandom}, 0, 1);
    for (int i = 0; i < 200; i++) begin
      do_op(oper_t'($urandom_range(0, 11)), pick(), pick(), {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(3);
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
